// File: rtl/pet_key_injector.sv
// pet_key_injector: buffers PET key codes from a byte stream and replays each one into
// the keyboard matrix, held for HOLD_TICKS scan ticks and released for GAP_TICKS ticks.
module pet_key_injector #(
   parameter int HOLD_TICKS = 3,
   parameter int GAP_TICKS  = 2,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       tick,
   input  logic [3:0] keyrow,
   output logic [7:0] keyin,
   output logic       busy,
   output logic       bad_code
);

   // state | meaning
   // IDLE  | no key active; pops the FIFO head when one is available
   // PRESS | key_reg held down until HOLD_TICKS ticks have been counted
   // GAP   | key released until GAP_TICKS ticks have been counted
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRESS = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [3:0]  HOLD_LAST = 4'(HOLD_TICKS - 1);
   localparam logic [3:0]  GAP_LAST  = 4'(GAP_TICKS - 1);

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fifo_cnt;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [7:0]    head;

   logic [1:0]    state;
   logic [3:0]    tick_cnt;
   logic [7:0]    key_reg;

   assign fifo_empty = (fifo_cnt == '0);
   assign in_ready   = (fifo_cnt != FULL_CNT);
   assign push       = in_valid && in_ready;
   assign pop        = (state == ST_IDLE) && !fifo_empty;
   assign head       = fifo_mem[rd_ptr];
   assign busy       = (state != ST_IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // The tick that lands on a state change is consumed by that change, never by the next state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         tick_cnt <= '0;
         key_reg  <= 8'h00;
         bad_code <= 1'b0;
      end else begin
         bad_code <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  key_reg  <= head;
                  tick_cnt <= '0;
                  if (head[6:3] <= 4'd9) begin
                     state <= ST_PRESS;
                  end else begin
                     bad_code <= 1'b1;
                  end
               end
            end
            ST_PRESS: begin
               if (tick) begin
                  if (tick_cnt == HOLD_LAST) begin
                     state    <= ST_GAP;
                     tick_cnt <= '0;
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            ST_GAP: begin
               if (tick) begin
                  if (tick_cnt == GAP_LAST) begin
                     state    <= ST_IDLE;
                     tick_cnt <= '0;
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               tick_cnt <= '0;
            end
         endcase
      end
   end

   // Shifted keys also pull the left-shift position (row 8, column 0).
   always_comb begin
      keyin = 8'hFF;
      if (state == ST_PRESS) begin
         if (keyrow == key_reg[6:3]) begin
            keyin[key_reg[2:0]] = 1'b0;
         end
         if (key_reg[7] && (keyrow == 4'd8)) begin
            keyin[0] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pet_key_injector.sv
// Self-checking bench for pet_key_injector: directed scenarios plus random traffic,
// compared every cycle against a remaining-tick reference model.
module tb_pet_key_injector;
   localparam int HOLD  = 3;
   localparam int GAP   = 2;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       tick;
   logic [3:0] keyrow;
   logic [7:0] keyin;
   logic       busy;
   logic       bad_code;

   pet_key_injector #(.HOLD_TICKS(HOLD), .GAP_TICKS(GAP), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .tick(tick), .keyrow(keyrow), .keyin(keyin),
      .busy(busy), .bad_code(bad_code)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: queued codes, the active key and the ticks it still owes (hold + gap).
   logic [7:0] m_fifo[$];
   bit         m_active;
   logic [7:0] m_key;
   int         m_left;
   bit         m_bad;
   bit         last_acc;
   int         bad_seen;

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
   endtask

   function automatic logic [7:0] key_pattern(input logic [7:0] code, input logic [3:0] kr);
      logic [7:0] r;
      r = 8'hFF;
      if (kr == code[6:3]) r = r & ~(8'd1 << code[2:0]);
      if (code[7] && kr == 4'd8) r = r & 8'hFE;
      return r;
   endfunction

   function automatic logic [7:0] exp_keyin(input logic [3:0] kr);
      if (m_active && m_left > GAP) return key_pattern(m_key, kr);
      return 8'hFF;
   endfunction

   function automatic logic [3:0] kr_pick();
      if (m_active && ($urandom % 4 != 0)) return m_key[6:3];
      return 4'($urandom_range(0, 15));
   endfunction

   task automatic step(input logic rn, input logic v, input logic [7:0] d,
                       input logic t, input logic [3:0] kr);
      logic exp_ready;
      reset_n = rn; in_valid = v; in_data = d; tick = t; keyrow = kr;
      #2;
      exp_ready = (m_fifo.size() < DEPTH);
      chk8("keyin", keyin, exp_keyin(kr));
      chk8("in_ready", {7'd0, in_ready}, {7'd0, exp_ready});
      chk8("busy", {7'd0, busy}, {7'd0, (m_active || m_fifo.size() != 0)});
      chk8("bad_code", {7'd0, bad_code}, {7'd0, m_bad});
      if (bad_code) bad_seen++;
      @(posedge clk);
      last_acc = rn && v && exp_ready;
      if (!rn) begin
         m_fifo.delete(); m_active = 0; m_bad = 0; m_left = 0;
      end else begin
         m_bad = 0;
         if (!m_active && m_fifo.size() > 0) begin
            m_key = m_fifo.pop_front();
            if (m_key[6:3] <= 4'd9) begin
               m_active = 1; m_left = HOLD + GAP;
            end else begin
               m_bad = 1;
            end
         end else if (m_active && t) begin
            m_left--;
            if (m_left == 0) m_active = 0;
         end
         if (last_acc) m_fifo.push_back(d);
      end
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] codes [24];
      int idx;
      int stray;
      int i;

      reset_n = 0; in_valid = 1; in_data = 8'h1A; tick = 0; keyrow = 4'd0;
      m_active = 0; m_bad = 0; m_left = 0; bad_seen = 0; m_key = 8'h00;
      @(posedge clk); #1;

      // reset held two cycles with valid asserted
      step(0, 1, 8'h1A, 0, 4'd3);
      step(0, 1, 8'h1A, 0, 4'd3);
      chk8("rst_ready", {7'd0, in_ready}, 8'd1);
      chk8("rst_busy", {7'd0, busy}, 8'd0);
      chk8("rst_keyin", keyin, 8'hFF);

      // single key, row 3 column 2, tick every 10 cycles
      for (int k = 0; k < 60; k++) begin
         step(1, k == 0, 8'h1A, (k % 10) == 9, (k == 15) ? 4'd4 : 4'd3);
         if (k == 1)  chk8("single_press", keyin, 8'hFB);
         if (k == 15) chk8("single_other_row", keyin, 8'hFF);
         if (k == 29) chk8("single_release", keyin, 8'hFF);
         if (k == 49) chk8("single_idle_busy", {7'd0, busy}, 8'd0);
      end

      // shifted key on row 8
      for (int k = 0; k < 30; k++) begin
         step(1, k == 0, 8'hC5, (k % 4) == 3, (k == 2) ? 4'd1 : 4'd8);
         if (k == 1) chk8("shift_press", keyin, 8'hDE);
         if (k == 2) chk8("shift_other_row", keyin, 8'hFF);
      end

      // fill the FIFO with ticks stopped, then drain with more codes still offered
      for (int k = 0; k < 24; k++) codes[k] = {1'($urandom), 4'($urandom_range(0, 9)), 3'($urandom)};
      idx = 0;
      for (int k = 0; k < 20; k++) begin
         step(1, 1, codes[idx], 0, kr_pick());
         if (last_acc) idx++;
      end
      chk8("fill_accepted", 8'(idx), 8'd17);
      chk8("fill_ready", {7'd0, in_ready}, 8'd0);
      i = 0;
      while (i < 1000 && (m_active || m_fifo.size() > 0 || idx < 24)) begin
         step(1, idx < 24, (idx < 24) ? codes[idx] : 8'h00, (i % 3) == 2, kr_pick());
         if (last_acc) idx++;
         i++;
      end
      chk8("fill_all_pushed", 8'(idx), 8'd24);
      chk8("fill_drain_busy", {7'd0, busy}, 8'd0);

      // invalid row 10 followed by row 1 column 0
      bad_seen = 0;
      for (int k = 0; k < 40; k++) begin
         step(1, k < 2, (k == 0) ? 8'h50 : 8'h08, (k % 3) == 2, 4'd1);
         if (k == 2) chk8("invalid_next_press", keyin, 8'hFE);
      end
      chk8("invalid_bad_pulses", 8'(bad_seen), 8'd1);

      // reset while pressing with three codes queued
      for (int k = 0; k < 6; k++) begin
         step(1, k < 4, 8'h11 + 8'(k) * 8'h11, 0, 4'd2);
      end
      chk8("midrst_pressing", keyin, 8'hFD);
      step(0, 0, 8'h00, 0, 4'd2);
      chk8("midrst_keyin", keyin, 8'hFF);
      chk8("midrst_busy", {7'd0, busy}, 8'd0);
      stray = 0;
      for (int k = 0; k < 60; k++) begin
         step(1, 0, 8'h00, (k % 3) == 2, 4'(2 + 2 * (k % 4)));
         if (keyin != 8'hFF) stray++;
      end
      chk8("midrst_no_press", 8'(stray), 8'd0);

      // random traffic with backpressure and occasional invalid rows
      for (int k = 0; k < 800; k++) begin
         step(1, ($urandom % 3) == 0,
              {1'($urandom), 4'($urandom_range(0, 11)), 3'($urandom)},
              ($urandom % 4) == 0, kr_pick());
      end
      i = 0;
      while (i < 2000 && (m_active || m_fifo.size() > 0)) begin
         step(1, 0, 8'h00, (i % 2) == 1, kr_pick());
         i++;
      end
      chk8("random_drain_busy", {7'd0, busy}, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
